ddr2_burst_sequencer: RTL and testbench
=======================================

DDR2_BURST_SEQUENCER -- requirements
Module: ddr2_burst_sequencer

Interface
REQ-001 SHALL have parameter BURST_LEN, default 32: words per MIG burst, legal range 1-64.
REQ-002 SHALL have parameter OB_DEPTH, default 1024: egress FIFO depth, in words.
REQ-003 SHALL have parameter MEM_BYTES_LOG2, default 27: log2 of the DDR2 byte span; addresses wrap at this span.
REQ-004 SHALL have port sys_clk, input, 1 bit: the only clock; every output is driven in this domain.
REQ-005 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have the following control and FIFO ports:
- calib_done, input, 1: MIG calibration complete.
- fifo_reset, input, 1: synchronous abort and clear.
- wr_mode, input, 1: enable writes (FrontPanel WireIn 0x00 bit 1).
- rd_mode, input, 1: enable reads (FrontPanel WireIn 0x00 bit 0).
- ib_data, input, 32: ingress FIFO data; the FIFO is first-word-fall-through.
- ib_rd_count, input, 10: words available in the ingress FIFO.
- ib_rd_en, output, 1: ingress FIFO pop.
- ob_wr_count, input, 10: words occupied in the egress FIFO.
- ob_wr_en, output, 1: egress FIFO push.
- ob_data, output, 32: egress FIFO data.
REQ-007 SHALL have the following MIG port-0 ports:
- p0_cmd_en, output, 1.
- p0_cmd_instr, output, 3.
- p0_cmd_bl, output, 6.
- p0_cmd_byte_addr, output, 30.
- p0_cmd_full, input, 1.
- p0_wr_en, output, 1.
- p0_wr_data, output, 32.
- p0_wr_mask, output, 4.
- p0_wr_full, input, 1.
- p0_rd_en, output, 1.
- p0_rd_data, input, 32.
- p0_rd_empty, input, 1.
REQ-008 SHALL have status outputs busy (1 bit, high whenever the state is not IDLE) and state (3 bits, current state encoding).

Function
REQ-009 SHALL implement five states: IDLE=0, WR_DATA=1, WR_CMD=2, RD_CMD=3, RD_WAIT=4.
REQ-010 SHALL move IDLE->WR_DATA when calib_done=1, wr_mode=1, ib_rd_count>=BURST_LEN and p0_cmd_full=0.
REQ-011 SHALL move IDLE->RD_CMD when calib_done=1, rd_mode=1, ob_wr_count<=OB_DEPTH-BURST_LEN, p0_cmd_full=0, and the write condition of REQ-010 is false; write therefore has priority when both modes are set.
REQ-012 SHALL, in WR_DATA, drive ib_rd_en = p0_wr_en = ~p0_wr_full and p0_wr_data = ib_data combinationally; words are counted only when p0_wr_full=0.
REQ-013 SHALL move WR_DATA->WR_CMD in the cycle after the BURST_LEN-th word is transferred.
REQ-014 SHALL, in WR_CMD, issue a command only when p0_cmd_full=0: p0_cmd_en=1 for exactly one cycle, instr=3'b000, bl=BURST_LEN-1, byte_addr=wr_addr; then return to IDLE.
REQ-015 SHALL, in RD_CMD, issue a command only when p0_cmd_full=0: p0_cmd_en=1 for one cycle, instr=3'b001, bl=BURST_LEN-1, byte_addr=rd_addr; then move to RD_WAIT.
REQ-016 SHALL, in RD_WAIT, drive p0_rd_en = ob_wr_en = ~p0_rd_empty and ob_data = p0_rd_data combinationally.
REQ-017 SHALL move RD_WAIT->IDLE in the cycle after the BURST_LEN-th word is received.
REQ-018 SHALL advance wr_addr (on the WR_CMD issue cycle) and rd_addr (on RD_WAIT completion) by BURST_LEN*4, modulo 2^MEM_BYTES_LOG2; upper address bits stay 0.
REQ-019 SHALL hold p0_wr_mask at 4'b0000 at all times.
REQ-020 SHALL hold p0_cmd_en, p0_wr_en, p0_rd_en, ib_rd_en and ob_wr_en at 0 outside the states that drive them.
REQ-021 SHALL keep p0_cmd_instr, p0_cmd_bl and p0_cmd_byte_addr stable whenever p0_cmd_en=1.
REQ-022 SHALL, on fifo_reset=1, go to IDLE on the next edge and clear wr_addr, rd_addr and the word counter, aborting any burst in progress; while fifo_reset=1 all enables of REQ-020 SHALL be 0 combinationally.
REQ-023 SHALL ignore a drop of wr_mode or rd_mode mid-burst; the current burst completes.
REQ-024 SHALL NOT leave IDLE while calib_done=0.

Reset
REQ-025 SHALL, while sys_rst_n=0, hold the following reset values:
- state=IDLE, busy=0.
- wr_addr=0, rd_addr=0, word counter=0.
- all enable outputs 0.
- p0_cmd_instr=0, p0_cmd_bl=0, p0_cmd_byte_addr=0.
- ob_data and p0_wr_data follow their sources.
REQ-026 SHALL apply reset asynchronously and release it synchronously to sys_clk.

Verification
REQ-027 SHALL cover write burst: calib_done=1, wr_mode=1, ib_rd_count=32 -> 32 p0_wr_en pulses, then one cmd_en with instr=0, bl=31, addr=0x0; the next burst uses addr 0x80.
REQ-028 SHALL cover write stall: p0_wr_full=1 for 5 cycles mid-burst -> exactly 32 words total, no duplicates, WR_CMD reached 5 cycles later than without the stall.
REQ-029 SHALL cover read burst: rd_mode=1, ob_wr_count=0, MIG returns 32 words with gaps -> cmd instr=1 at addr 0x0, ob_wr_en count=32, data matches MIG order.
REQ-030 SHALL cover arbitration and backpressure:
- both modes set, ib_rd_count>=32 -> write burst first.
- ob_wr_count=993 -> no read command issued.
REQ-031 SHALL cover wrap-around: MEM_BYTES_LOG2=8, eight write bursts -> addresses 0x00, 0x80, 0x00, 0x80, ... (wrap at 256 bytes).
REQ-032 SHALL cover aborts:
- fifo_reset asserted mid-RD_WAIT -> state=IDLE next cycle, rd_addr=0, p0_rd_en=0 while asserted.
- sys_rst_n pulsed mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ddr2_burst_sequencer.sv
// ---------------------------------------------------------------------------
// ddr2_burst_sequencer
//
// Moves fixed-length bursts between a pair of host FIFOs and MIG port 0.
// Write path: ingress FIFO (first-word-fall-through) -> MIG write FIFO, then
// one write command. Read path: one read command, then MIG read FIFO ->
// egress FIFO. Write and read addresses advance independently by one burst
// and wrap at 2^MEM_BYTES_LOG2 bytes.
//
// Ports
//   sys_clk, sys_rst_n     : clock, asynchronous active-low reset
//   calib_done             : MIG calibration complete (gates every burst)
//   fifo_reset             : synchronous abort, clears addresses and counter
//   wr_mode / rd_mode      : enable write / read bursts (write wins)
//   ib_data, ib_rd_count   : ingress FIFO head word and fill level
//   ib_rd_en               : ingress FIFO pop
//   ob_wr_count            : egress FIFO fill level
//   ob_wr_en, ob_data      : egress FIFO push and data
//   p0_cmd_*               : MIG command port
//   p0_wr_*                : MIG write data port
//   p0_rd_*                : MIG read data port
//   busy, state            : status (state encoding of the sequencer)
// ---------------------------------------------------------------------------
module ddr2_burst_sequencer #(
  parameter int BURST_LEN      = 32,
  parameter int OB_DEPTH       = 1024,
  parameter int MEM_BYTES_LOG2 = 27
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        calib_done,
  input  logic        fifo_reset,
  input  logic        wr_mode,
  input  logic        rd_mode,
  input  logic [31:0] ib_data,
  input  logic [9:0]  ib_rd_count,
  output logic        ib_rd_en,
  input  logic [9:0]  ob_wr_count,
  output logic        ob_wr_en,
  output logic [31:0] ob_data,
  output logic        p0_cmd_en,
  output logic [2:0]  p0_cmd_instr,
  output logic [5:0]  p0_cmd_bl,
  output logic [29:0] p0_cmd_byte_addr,
  input  logic        p0_cmd_full,
  output logic        p0_wr_en,
  output logic [31:0] p0_wr_data,
  output logic [3:0]  p0_wr_mask,
  input  logic        p0_wr_full,
  output logic        p0_rd_en,
  input  logic [31:0] p0_rd_data,
  input  logic        p0_rd_empty,
  output logic        busy,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_CMD  = 3'd2,
    RD_CMD  = 3'd3,
    RD_WAIT = 3'd4
  } state_t;

  localparam logic [10:0] BURST_WORDS = 11'(BURST_LEN);
  localparam logic [6:0]  LAST_WORD   = 7'(BURST_LEN - 1);
  localparam logic [5:0]  CMD_BL      = 6'(BURST_LEN - 1);
  localparam logic [MEM_BYTES_LOG2-1:0] BURST_BYTES = MEM_BYTES_LOG2'(BURST_LEN * 4);
  // A read is only started when the whole burst is guaranteed to fit in the
  // egress FIFO, so RD_WAIT never has to stall on it.
  localparam int unsigned OB_LIMIT = OB_DEPTH - BURST_LEN;

  state_t                    state_reg;
  logic [6:0]                word_cnt_reg;
  logic [MEM_BYTES_LOG2-1:0] wr_addr_reg;
  logic [MEM_BYTES_LOG2-1:0] rd_addr_reg;
  logic [2:0]                cmd_instr_reg;
  logic [5:0]                cmd_bl_reg;
  logic [29:0]               cmd_addr_reg;

  logic wr_go;
  logic rd_go;
  logic wr_xfer;
  logic rd_xfer;
  logic cmd_issue;
  logic last_word;

  assign wr_go = calib_done & wr_mode & ({1'b0, ib_rd_count} >= BURST_WORDS) & ~p0_cmd_full;
  assign rd_go = calib_done & rd_mode & (32'(ob_wr_count) <= OB_LIMIT) & ~p0_cmd_full;

  // Data-path handshakes are combinational so a word moves in the same
  // cycle the far side reports room/data; fifo_reset kills them instantly.
  assign wr_xfer   = (state_reg == WR_DATA) & ~p0_wr_full & ~fifo_reset;
  assign rd_xfer   = (state_reg == RD_WAIT) & ~p0_rd_empty & ~fifo_reset;
  assign cmd_issue = ((state_reg == WR_CMD) | (state_reg == RD_CMD)) & ~p0_cmd_full & ~fifo_reset;
  assign last_word = (word_cnt_reg == LAST_WORD);

  assign ib_rd_en   = wr_xfer;
  assign p0_wr_en   = wr_xfer;
  assign p0_wr_data = ib_data;
  assign p0_wr_mask = 4'b0000;
  assign p0_rd_en   = rd_xfer;
  assign ob_wr_en   = rd_xfer;
  assign ob_data    = p0_rd_data;
  assign p0_cmd_en  = cmd_issue;

  // Command fields are loaded on entry to the command state and held, so
  // they are already stable in every cycle p0_cmd_en can be high.
  assign p0_cmd_instr     = cmd_instr_reg;
  assign p0_cmd_bl        = cmd_bl_reg;
  assign p0_cmd_byte_addr = cmd_addr_reg;

  assign busy  = (state_reg != IDLE);
  assign state = state_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg     <= IDLE;
      word_cnt_reg  <= '0;
      wr_addr_reg   <= '0;
      rd_addr_reg   <= '0;
      cmd_instr_reg <= '0;
      cmd_bl_reg    <= '0;
      cmd_addr_reg  <= '0;
    end else if (fifo_reset) begin
      state_reg    <= IDLE;
      word_cnt_reg <= '0;
      wr_addr_reg  <= '0;
      rd_addr_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          word_cnt_reg <= '0;
          if (wr_go) begin
            state_reg <= WR_DATA;
          end else if (rd_go) begin
            state_reg     <= RD_CMD;
            cmd_instr_reg <= 3'b001;
            cmd_bl_reg    <= CMD_BL;
            cmd_addr_reg  <= 30'(rd_addr_reg);
          end
        end
        WR_DATA: begin
          if (wr_xfer) begin
            if (last_word) begin
              state_reg     <= WR_CMD;
              word_cnt_reg  <= '0;
              cmd_instr_reg <= 3'b000;
              cmd_bl_reg    <= CMD_BL;
              cmd_addr_reg  <= 30'(wr_addr_reg);
            end else begin
              word_cnt_reg <= word_cnt_reg + 7'd1;
            end
          end
        end
        WR_CMD: begin
          if (cmd_issue) begin
            wr_addr_reg <= wr_addr_reg + BURST_BYTES;
            state_reg   <= IDLE;
          end
        end
        RD_CMD: begin
          if (cmd_issue) begin
            state_reg    <= RD_WAIT;
            word_cnt_reg <= '0;
          end
        end
        RD_WAIT: begin
          if (rd_xfer) begin
            if (last_word) begin
              state_reg    <= IDLE;
              word_cnt_reg <= '0;
              rd_addr_reg  <= rd_addr_reg + BURST_BYTES;
            end else begin
              word_cnt_reg <= word_cnt_reg + 7'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ddr2_burst_sequencer
//
// Bench for ddr2_burst_sequencer with a 256-byte address span so wrap-around
// is exercised. Behavioural models stand in for the ingress FIFO and the MIG
// read port; a negedge monitor pops expected words/commands from queues.
// ---------------------------------------------------------------------------
module tb_ddr2_burst_sequencer;

  localparam int BL  = 32;
  localparam int OBD = 1024;
  localparam int MBL = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        calib_done;
  logic        fifo_reset;
  logic        wr_mode;
  logic        rd_mode;
  logic [31:0] ib_data;
  logic [9:0]  ib_rd_count;
  logic        ib_rd_en;
  logic [9:0]  ob_wr_count;
  logic        ob_wr_en;
  logic [31:0] ob_data;
  logic        p0_cmd_en;
  logic [2:0]  p0_cmd_instr;
  logic [5:0]  p0_cmd_bl;
  logic [29:0] p0_cmd_byte_addr;
  logic        p0_cmd_full;
  logic        p0_wr_en;
  logic [31:0] p0_wr_data;
  logic [3:0]  p0_wr_mask;
  logic        p0_wr_full;
  logic        p0_rd_en;
  logic [31:0] p0_rd_data;
  logic        p0_rd_empty;
  logic        busy;
  logic [2:0]  state;

  always #5 sys_clk = ~sys_clk;

  ddr2_burst_sequencer #(
    .BURST_LEN(BL), .OB_DEPTH(OBD), .MEM_BYTES_LOG2(MBL)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .calib_done(calib_done),
    .fifo_reset(fifo_reset), .wr_mode(wr_mode), .rd_mode(rd_mode),
    .ib_data(ib_data), .ib_rd_count(ib_rd_count), .ib_rd_en(ib_rd_en),
    .ob_wr_count(ob_wr_count), .ob_wr_en(ob_wr_en), .ob_data(ob_data),
    .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl),
    .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_full(p0_cmd_full),
    .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask),
    .p0_wr_full(p0_wr_full), .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data),
    .p0_rd_empty(p0_rd_empty), .busy(busy), .state(state)
  );

  typedef struct packed {
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] addr;
  } cmd_t;

  int n_cmp = 0;
  int n_mis = 0;

  cmd_t        exp_cmd_q[$];
  logic [31:0] ib_q[$];
  logic [31:0] exp_wr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] exp_ob_q[$];

  int          cyc = 0;
  int          wr_words = 0;
  int          ob_words = 0;
  int          cmd_seen = 0;
  int          t_first = 0;
  int          t_wrcmd = 0;
  bit          pop_ib = 0;
  bit          pop_rd = 0;
  bit          rd_gap = 1;
  logic [2:0]  prev_state = 3'd0;
  logic [29:0] exp_wr_addr = 30'd0;
  logic [29:0] exp_rd_addr = 30'd0;
  logic [29:0] last_cmd_addr = 30'd0;
  logic [2:0]  last_cmd_instr = 3'd0;

  logic [31:0] mon_w;
  logic [31:0] mdl_w;
  cmd_t        mon_c;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge sys_clk) begin
    cyc++;
    if (p0_wr_en) begin
      n_cmp++;
      if (exp_wr_q.size() == 0) begin
        n_mis++;
        $display("FAIL wr_extra: got write %h, required no write", p0_wr_data);
      end else begin
        mon_w = exp_wr_q.pop_front();
        if (p0_wr_data !== mon_w || ib_rd_en !== 1'b1 || p0_wr_mask !== 4'b0000) begin
          n_mis++;
          $display("FAIL wr_word: got data=%h ib_rd_en=%b mask=%b, required data=%h ib_rd_en=1 mask=0",
                   p0_wr_data, ib_rd_en, p0_wr_mask, mon_w);
        end
      end
      if (wr_words == 0) t_first = cyc;
      wr_words++;
      pop_ib = 1;
    end
    if (ob_wr_en) begin
      n_cmp++;
      if (exp_ob_q.size() == 0) begin
        n_mis++;
        $display("FAIL ob_extra: got push %h, required no push", ob_data);
      end else begin
        mon_w = exp_ob_q.pop_front();
        if (ob_data !== mon_w || p0_rd_en !== 1'b1) begin
          n_mis++;
          $display("FAIL ob_word: got data=%h p0_rd_en=%b, required data=%h p0_rd_en=1",
                   ob_data, p0_rd_en, mon_w);
        end
      end
      ob_words++;
      pop_rd = 1;
    end
    if (p0_cmd_en) begin
      n_cmp++;
      $display("cmd %0d: instr=%0d bl=%0d addr=0x%0h", cmd_seen, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr);
      if (exp_cmd_q.size() == 0) begin
        n_mis++;
        $display("FAIL cmd_extra: got instr=%0d addr=0x%0h, required no command", p0_cmd_instr, p0_cmd_byte_addr);
      end else begin
        mon_c = exp_cmd_q.pop_front();
        if (p0_cmd_instr !== mon_c.instr || p0_cmd_bl !== mon_c.bl || p0_cmd_byte_addr !== mon_c.addr) begin
          n_mis++;
          $display("FAIL cmd_fields: got instr=%0d bl=%0d addr=0x%0h, required instr=%0d bl=%0d addr=0x%0h",
                   p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr, mon_c.instr, mon_c.bl, mon_c.addr);
        end
      end
      last_cmd_addr  = p0_cmd_byte_addr;
      last_cmd_instr = p0_cmd_instr;
      cmd_seen++;
      // MIG model: a read command makes one burst of data available.
      if (p0_cmd_instr == 3'd1) begin
        for (int i = 0; i < BL; i++) begin
          mon_w = $urandom;
          rd_q.push_back(mon_w);
          exp_ob_q.push_back(mon_w);
        end
      end
    end
    if (state == 3'd2 && prev_state != 3'd2) t_wrcmd = cyc;
    prev_state = state;
  end

  // ---------------- FIFO / MIG models ----------------
  always @(posedge sys_clk) begin
    #1;
    if (pop_ib) begin
      if (ib_q.size() > 0) mdl_w = ib_q.pop_front();
      pop_ib = 0;
    end
    if (pop_rd) begin
      if (rd_q.size() > 0) mdl_w = rd_q.pop_front();
      pop_rd = 0;
    end
    ib_data     = (ib_q.size() > 0) ? ib_q[0] : 32'hA5A5_5A5A;
    ib_rd_count = (ib_q.size() > 1023) ? 10'd1023 : 10'(ib_q.size());
    p0_rd_data  = (rd_q.size() > 0) ? rd_q[0] : 32'h5A5A_A5A5;
    p0_rd_empty = (rd_q.size() == 0) || (rd_gap && ($urandom_range(0, 2) == 0));
  end

  // ---------------- helpers (stimulus / waiting only) ----------------
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic start_write();
    cmd_t c;
    for (int i = 0; i < BL; i++) begin
      logic [31:0] w;
      w = $urandom;
      ib_q.push_back(w);
      exp_wr_q.push_back(w);
    end
    c.instr = 3'd0;
    c.bl    = 6'(BL - 1);
    c.addr  = exp_wr_addr;
    exp_cmd_q.push_back(c);
    exp_wr_addr = (exp_wr_addr + 30'd128) & 30'hFF;
  endtask

  task automatic expect_read();
    cmd_t c;
    c.instr = 3'd1;
    c.bl    = 6'(BL - 1);
    c.addr  = exp_rd_addr;
    exp_cmd_q.push_back(c);
    exp_rd_addr = (exp_rd_addr + 30'd128) & 30'hFF;
  endtask

  task automatic wait_cmd(input int target, output bit ok);
    for (int i = 0; i < 400 && cmd_seen < target; i++) tick();
    ok = (cmd_seen >= target);
  endtask

  task automatic wait_read_done(output bit ok);
    for (int i = 0; i < 400 && !(ob_words >= BL && state == 3'd0); i++) tick();
    ok = (ob_words >= BL && state == 3'd0);
  endtask

  task automatic wait_words(input int n, output bit ok);
    for (int i = 0; i < 400 && wr_words < n; i++) tick();
    ok = (wr_words >= n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sys_rst_n = 1'b0; calib_done = 1'b0; fifo_reset = 1'b0;
    wr_mode = 1'b0; rd_mode = 1'b0; ob_wr_count = 10'd0;
    p0_cmd_full = 1'b0; p0_wr_full = 1'b0;
    ib_data = 32'hA5A5_5A5A; ib_rd_count = 10'd0;
    p0_rd_data = 32'h5A5A_A5A5; p0_rd_empty = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_state: got state=%0d busy=%b, required 0/0", state, busy);
    end
    n_cmp++;
    if ({p0_cmd_en, p0_wr_en, p0_rd_en, ib_rd_en, ob_wr_en} !== 5'b0) begin
      n_mis++;
      $display("FAIL reset_enables: got %b, required 00000", {p0_cmd_en, p0_wr_en, p0_rd_en, ib_rd_en, ob_wr_en});
    end
    n_cmp++;
    if (p0_cmd_instr !== 3'd0 || p0_cmd_bl !== 6'd0 || p0_cmd_byte_addr !== 30'd0 || p0_wr_mask !== 4'd0) begin
      n_mis++;
      $display("FAIL reset_cmd: got instr=%0d bl=%0d addr=%0h mask=%b, required all 0",
               p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr, p0_wr_mask);
    end
    n_cmp++;
    if (p0_wr_data !== 32'hA5A5_5A5A || ob_data !== 32'h5A5A_A5A5) begin
      n_mis++;
      $display("FAIL reset_passthru: got wr_data=%h ob_data=%h, required a5a55a5a/5a5aa5a5", p0_wr_data, ob_data);
    end
    sys_rst_n = 1'b1;
    tick();
    // calib_done low must keep the sequencer parked even with a read possible
    rd_mode = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (state !== 3'd0 || cmd_seen != 0) begin
      n_mis++;
      $display("FAIL calib_gate: got state=%0d cmds=%0d, required 0/0", state, cmd_seen);
    end
    rd_mode = 1'b0;
    tick();
    calib_done = 1'b1;
    tick();
  endtask

  task automatic test_write_burst();
    bit ok;
    for (int b = 0; b < 2; b++) begin
      wr_words = 0;
      start_write();
      wr_mode = 1'b1;
      wait_cmd(cmd_seen + 1, ok);
      n_cmp++;
      if (!ok) begin
        n_mis++;
        $display("FAIL wr_burst_timeout: got no command, required write command");
      end
      n_cmp++;
      if (wr_words != BL || exp_wr_q.size() != 0 || last_cmd_addr !== ((b == 0) ? 30'h0 : 30'h80)) begin
        n_mis++;
        $display("FAIL wr_burst: got words=%0d left=%0d addr=0x%0h, required words=32 left=0 addr=0x%0h",
                 wr_words, exp_wr_q.size(), last_cmd_addr, (b == 0) ? 30'h0 : 30'h80);
      end
      n_cmp++;
      if (t_wrcmd - t_first != 32) begin
        n_mis++;
        $display("FAIL wr_latency: got %0d cycles to WR_CMD, required 32", t_wrcmd - t_first);
      end
      tick();
      n_cmp++;
      if (state !== 3'd0) begin
        n_mis++;
        $display("FAIL wr_return_idle: got state=%0d, required 0", state);
      end
    end
    wr_mode = 1'b0;
  endtask

  task automatic test_write_stall();
    bit ok;
    wr_words = 0;
    start_write();
    wr_mode = 1'b1;
    wait_words(10, ok);
    p0_wr_full = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if (wr_words != 10 || p0_wr_en !== 1'b0) begin
      n_mis++;
      $display("FAIL wr_stall_hold: got words=%0d wr_en=%b, required 10/0", wr_words, p0_wr_en);
    end
    p0_wr_full = 1'b0;
    wait_cmd(cmd_seen + 1, ok);
    n_cmp++;
    if (!ok || wr_words != BL || exp_wr_q.size() != 0 || t_wrcmd - t_first != 37) begin
      n_mis++;
      $display("FAIL wr_stall: got ok=%0d words=%0d left=%0d latency=%0d, required 1/32/0/37",
               ok, wr_words, exp_wr_q.size(), t_wrcmd - t_first);
    end
    wr_mode = 1'b0;
    tick();
  endtask

  task automatic test_read_burst();
    bit ok;
    ob_words = 0;
    ob_wr_count = 10'd0;
    expect_read();
    rd_mode = 1'b1;
    wait_cmd(cmd_seen + 1, ok);
    rd_mode = 1'b0;   // dropped mid-burst: the burst must still finish
    n_cmp++;
    if (!ok || last_cmd_instr !== 3'd1 || last_cmd_addr !== 30'h0) begin
      n_mis++;
      $display("FAIL rd_cmd: got ok=%0d instr=%0d addr=0x%0h, required 1/1/0x0", ok, last_cmd_instr, last_cmd_addr);
    end
    wait_read_done(ok);
    n_cmp++;
    if (!ok || ob_words != BL || exp_ob_q.size() != 0) begin
      n_mis++;
      $display("FAIL rd_burst: got ok=%0d words=%0d left=%0d, required 1/32/0", ok, ob_words, exp_ob_q.size());
    end
  endtask

  task automatic test_arbitration();
    bit ok;
    int c0;
    wr_words = 0;
    ob_words = 0;
    start_write();
    expect_read();
    repeat (2) tick();
    c0 = cmd_seen;
    wr_mode = 1'b1;
    rd_mode = 1'b1;
    tick();
    n_cmp++;
    if (state !== 3'd1) begin
      n_mis++;
      $display("FAIL arb_first: got state=%0d, required 1 (WR_DATA)", state);
    end
    wait_cmd(c0 + 2, ok);
    rd_mode = 1'b0;
    wr_mode = 1'b0;
    wait_read_done(ok);
    n_cmp++;
    if (!ok || wr_words != BL || ob_words != BL || exp_cmd_q.size() != 0) begin
      n_mis++;
      $display("FAIL arb_both: got ok=%0d wr=%0d rd=%0d cmds_left=%0d, required 1/32/32/0",
               ok, wr_words, ob_words, exp_cmd_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int c0;
    c0 = cmd_seen;
    ob_words = 0;
    ob_wr_count = 10'd993;
    rd_mode = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if (cmd_seen != c0 || state !== 3'd0) begin
      n_mis++;
      $display("FAIL ob_full_block: got cmds=%0d state=%0d, required %0d/0", cmd_seen, state, c0);
    end
    expect_read();
    ob_wr_count = 10'd992;
    wait_cmd(c0 + 1, ok);
    rd_mode = 1'b0;
    wait_read_done(ok);
    n_cmp++;
    if (!ok || ob_words != BL) begin
      n_mis++;
      $display("FAIL ob_boundary: got ok=%0d words=%0d, required 1/32", ok, ob_words);
    end
    ob_wr_count = 10'd0;
  endtask

  task automatic test_cmd_full();
    bit ok;
    int c0;
    wr_words = 0;
    start_write();
    wr_mode = 1'b1;
    wait_words(5, ok);
    p0_cmd_full = 1'b1;
    for (int i = 0; i < 100 && state != 3'd2; i++) tick();
    c0 = cmd_seen;
    repeat (3) tick();
    n_cmp++;
    if (state !== 3'd2 || cmd_seen != c0 || p0_cmd_en !== 1'b0) begin
      n_mis++;
      $display("FAIL cmd_full_hold: got state=%0d cmds=%0d cmd_en=%b, required 2/%0d/0", state, cmd_seen, p0_cmd_en, c0);
    end
    p0_cmd_full = 1'b0;
    wait_cmd(c0 + 1, ok);
    tick();
    n_cmp++;
    if (!ok || state !== 3'd0) begin
      n_mis++;
      $display("FAIL cmd_full_release: got ok=%0d state=%0d, required 1/0", ok, state);
    end
    wr_mode = 1'b0;
  endtask

  task automatic test_fifo_reset();
    bit ok;
    rd_gap = 0;
    ob_words = 0;
    expect_read();
    rd_mode = 1'b1;
    wait_cmd(cmd_seen + 1, ok);
    rd_mode = 1'b0;
    for (int i = 0; i < 100 && ob_words < 10; i++) tick();
    fifo_reset = 1'b1;
    #1;
    n_cmp++;
    if (p0_rd_en !== 1'b0 || ob_wr_en !== 1'b0) begin
      n_mis++;
      $display("FAIL fifo_reset_gate: got rd_en=%b ob_wr_en=%b, required 0/0", p0_rd_en, ob_wr_en);
    end
    tick();
    n_cmp++;
    if (state !== 3'd0 || busy !== 1'b0 || p0_rd_en !== 1'b0) begin
      n_mis++;
      $display("FAIL fifo_reset_idle: got state=%0d busy=%b rd_en=%b, required 0/0/0", state, busy, p0_rd_en);
    end
    fifo_reset = 1'b0;
    rd_q.delete();
    exp_ob_q.delete();
    exp_rd_addr = 30'd0;
    exp_wr_addr = 30'd0;
    rd_gap = 1;
    tick();
    // rd_addr must restart at 0 (checked through the command scoreboard)
    ob_words = 0;
    expect_read();
    rd_mode = 1'b1;
    wait_cmd(cmd_seen + 1, ok);
    rd_mode = 1'b0;
    wait_read_done(ok);
    n_cmp++;
    if (!ok || last_cmd_addr !== 30'h0 || ob_words != BL) begin
      n_mis++;
      $display("FAIL fifo_reset_addr: got ok=%0d addr=0x%0h words=%0d, required 1/0x0/32", ok, last_cmd_addr, ob_words);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    for (int b = 0; b < 8; b++) begin
      wr_words = 0;
      start_write();
      wr_mode = 1'b1;
      wait_cmd(cmd_seen + 1, ok);
      n_cmp++;
      if (!ok || wr_words != BL || last_cmd_addr !== ((b % 2 == 0) ? 30'h00 : 30'h80)) begin
        n_mis++;
        $display("FAIL wrap_%0d: got ok=%0d words=%0d addr=0x%0h, required 1/32/0x%0h",
                 b, ok, wr_words, last_cmd_addr, (b % 2 == 0) ? 30'h00 : 30'h80);
      end
    end
    wr_mode = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bit ok;
    wr_words = 0;
    start_write();
    wr_mode = 1'b1;
    wait_words(10, ok);
    #1;
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state !== 3'd0 || busy !== 1'b0 || {p0_cmd_en, p0_wr_en, p0_rd_en, ib_rd_en, ob_wr_en} !== 5'b0) begin
      n_mis++;
      $display("FAIL async_reset_state: got state=%0d busy=%b en=%b, required 0/0/00000",
               state, busy, {p0_cmd_en, p0_wr_en, p0_rd_en, ib_rd_en, ob_wr_en});
    end
    n_cmp++;
    if (p0_cmd_instr !== 3'd0 || p0_cmd_bl !== 6'd0 || p0_cmd_byte_addr !== 30'd0) begin
      n_mis++;
      $display("FAIL async_reset_cmd: got instr=%0d bl=%0d addr=0x%0h, required 0/0/0",
               p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr);
    end
    wr_mode = 1'b0;
    ib_q.delete();
    exp_wr_q.delete();
    exp_cmd_q.delete();
    exp_wr_addr = 30'd0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
    tick();
    wr_words = 0;
    start_write();
    wr_mode = 1'b1;
    wait_cmd(cmd_seen + 1, ok);
    n_cmp++;
    if (!ok || last_cmd_addr !== 30'h0 || wr_words != BL || exp_wr_q.size() != 0) begin
      n_mis++;
      $display("FAIL async_reset_resume: got ok=%0d addr=0x%0h words=%0d, required 1/0x0/32", ok, last_cmd_addr, wr_words);
    end
    wr_mode = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_write_stall();
    test_read_burst();
    test_arbitration();
    test_backpressure();
    test_cmd_full();
    test_fifo_reset();
    test_wrap();
    test_async_reset();
    n_cmp++;
    if (exp_cmd_q.size() != 0 || exp_wr_q.size() != 0 || exp_ob_q.size() != 0) begin
      n_mis++;
      $display("FAIL leftover: got cmd=%0d wr=%0d ob=%0d pending, required 0/0/0",
               exp_cmd_q.size(), exp_wr_q.size(), exp_ob_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_mis + 1);
    $fatal(1, "watchdog");
  end

endmodule
